matrix_bank_regfile: RTL
========================

Name: matrix_bank_regfile

Overview:
Multi-bank 2-D matrix register file for the FM matrix datapath. It replaces the fixed single-cycle packed register file with a parametrised version that adds:
- configurable read latency
- write-to-read forwarding
- address range checking
- a per-bank hardware clear sequencer
Each bank has one independent write port and one independent read port, so NUMBANKS matrix tiles can be accessed concurrently by the compute lanes.

Parameters:
DW, 16, data word width in bits
ROWS, 8, matrix rows per bank (≥2)
COLS, 8, matrix columns per bank (≥2)
NUMBANKS, 4, independent banks/ports (≥1)
RD_LAT, 1, read latency in cycles; legal values 1 or 2 (elaboration error otherwise)
WR_FWD, 1, 1 = a same-cycle same-address read returns the new write data; 0 = it returns the old data

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wren[0:NUMBANKS-1]  in  1  write enable per bank
row_wr_addr[0:NUMBANKS-1]  in  RW=$clog2(ROWS)+1  write row
col_wr_addr[0:NUMBANKS-1]  in  CW=$clog2(COLS)+1  write column
wr_data[0:NUMBANKS-1]  in  DW  write data
rden[0:NUMBANKS-1]  in  1  read enable per bank
row_rd_addr[0:NUMBANKS-1]  in  RW  read row
col_rd_addr[0:NUMBANKS-1]  in  CW  read column
rd_data[0:NUMBANKS-1]  out  DW  read data
rd_valid[0:NUMBANKS-1]  out  1  rd_data valid strobe
clr_req[0:NUMBANKS-1]  in  1  start a bank clear (single-cycle pulse)
clr_busy[0:NUMBANKS-1]  out  1  bank clear in progress
addr_err[0:NUMBANKS-1]  out  1  one-cycle out-of-range access pulse

Behaviour:
- Address ports carry one extra MSB so that out-of-range values can be detected.
- Reset (async assert, sync deassert): rd_data=0, rd_valid=0, clr_busy=0, addr_err=0, read pipelines flushed, clear FSMs in IDLE. Storage is not reset.
- Write: if wren and row<ROWS and col<COLS, the entry is updated at the clk edge.
- Read: rden sampled at edge N gives rd_valid=1 and rd_data at edge N+RD_LAT.
  - rd_valid is high for exactly one cycle per accepted rden.
  - rd_data holds its last value when rd_valid=0.
- Back-to-back reads are fully pipelined at 1 per cycle.
- Same-cycle write and read to the same in-range address:
  - WR_FWD=1: the read returns wr_data.
  - WR_FWD=0: the read returns the previous content.
- Out-of-range address on an enabled port:
  - write: dropped.
  - read: still produces rd_valid at the normal latency, with rd_data=0.
  - addr_err pulses 1 cycle after the offending edge.
  - A bad read and a bad write in the same cycle produce a single pulse.
- Clear FSM, one per bank, states IDLE and CLEAR:
  - IDLE→CLEAR on clr_req. clr_busy rises at the next edge.
  - In CLEAR, a counter idx runs 0..ROWS*COLS-1. Each cycle, entry (idx/COLS, idx%COLS) is written to 0.
  - CLEAR→IDLE after idx=ROWS*COLS-1. clr_busy is high for exactly ROWS*COLS cycles.
  - clr_req while in CLEAR is ignored (no restart).
  - User writes during CLEAR are dropped, with no addr_err.
  - Reads during CLEAR return rd_data=0 with normal rd_valid timing.
  - rst_n asserted mid-clear: FSM→IDLE, clr_busy=0, contents undefined.
- Banks are fully independent: activity on bank i never affects bank j.

Decomposition:
- Package matrix_regfile_pkg holds:
  - the clear-state enum typedef (CLR_IDLE, CLR_RUN)
  - constants RD_LAT_MIN=1 and RD_LAT_MAX=2
  - a function for address legality
- Sub-module regfile_bank: one bank containing storage, read pipeline, forwarding, range check and clear FSM.
- The top instantiates NUMBANKS copies in a generate loop.

Test Plan:
- Defaults; bank0 write (2,3)=16'hA5A5, then rden (2,3) → rd_valid and 16'hA5A5 one cycle later. Banks 1–3 unaffected (read 0 after clear).
- RD_LAT=2; rden on 4 consecutive cycles to (0,0)..(0,3) pre-loaded with 1..4 → rd_valid high 4 cycles starting 2 edges later, data 1,2,3,4.
- Same-cycle write (5,5)=16'h1234 over old 16'h0F0F plus read (5,5) → 16'h1234 with WR_FWD=1; 16'h0F0F with WR_FWD=0.
- Bank1 write row=8 col=0 then read row=0 col=9 → addr_err pulses twice, no storage change, rd_data=0 with rd_valid.
- clr_req on bank2 after filling it with 16'hFFFF → clr_busy high exactly 64 cycles. A write during that window is dropped, and a second clr_req is ignored. Afterwards all 64 reads return 0.
- rst_n low at clear cycle 20 → clr_busy=0 and rd_valid=0 immediately (async). After release, a new clr_req clears the full 64 cycles.

Source files
------------

// File: rtl/matrix_bank_regfile_pkg.sv
// Shared types and helpers for the multi-bank matrix register file.
package matrix_regfile_pkg;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic logic addr_in_range(input int unsigned row, input int unsigned col,
                                         input int unsigned rows, input int unsigned cols);
    return (row < rows) && (col < cols);
  endfunction

endpackage

// File: rtl/matrix_bank_regfile_bank.sv
// One matrix bank: storage, RD_LAT-deep read pipeline, write forwarding, range check, clear sequencer.
// Read data RD_LAT edges after rden at 1/cycle; no backpressure, user writes are dropped while clearing.
module regfile_bank
  import matrix_regfile_pkg::*;
#(
  parameter int DW     = 16,
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int RD_LAT = 1,
  parameter int WR_FWD = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wren,
  input  logic [$clog2(ROWS):0] row_wr_addr,
  input  logic [$clog2(COLS):0] col_wr_addr,
  input  logic [DW-1:0]         wr_data,
  input  logic                  rden,
  input  logic [$clog2(ROWS):0] row_rd_addr,
  input  logic [$clog2(COLS):0] col_rd_addr,
  output logic [DW-1:0]         rd_data,
  output logic                  rd_valid,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  addr_err
);

  localparam int NENT = ROWS * COLS;
  localparam int AW   = $clog2(NENT);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          clr_run;

  logic [DW-1:0] mem_q [NENT];
  logic [DW-1:0] mem_d [NENT];

  logic          wr_legal, rd_legal, wr_take, fwd_hit;
  logic [AW-1:0] wr_idx, rd_idx;
  logic [DW-1:0] rd_val;

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [DW-1:0]     dat_q [RD_LAT];
  logic [DW-1:0]     dat_d [RD_LAT];
  logic              addr_err_q, addr_err_d;

  // Clear sequencer: state register / next state / outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLR_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = '0;
    case (state_q)
      CLR_IDLE: if (clr_req) state_d = CLR_RUN;
      CLR_RUN: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(NENT - 1)) begin
          state_d = CLR_IDLE;
          idx_d   = '0;
        end
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  always_comb begin
    clr_run  = (state_q == CLR_RUN);
    clr_busy = clr_run;
  end

  always_comb begin
    wr_legal = addr_in_range(32'(row_wr_addr), 32'(col_wr_addr), ROWS, COLS);
    rd_legal = addr_in_range(32'(row_rd_addr), 32'(col_rd_addr), ROWS, COLS);
    wr_idx   = AW'(32'(row_wr_addr) * COLS + 32'(col_wr_addr));
    rd_idx   = AW'(32'(row_rd_addr) * COLS + 32'(col_rd_addr));
    wr_take  = wren && wr_legal && !clr_run;
    fwd_hit  = (WR_FWD != 0) && wr_take && (wr_idx == rd_idx);
    if (!rd_legal || clr_run) begin
      rd_val = '0;
    end else if (fwd_hit) begin
      rd_val = wr_data;
    end else begin
      rd_val = mem_q[rd_idx];
    end
    // Writes rejected by an active clear are not address errors.
    addr_err_d = (wren && !wr_legal && !clr_run) || (rden && !rd_legal);
  end

  always_comb begin
    mem_d = mem_q;
    if (clr_run) begin
      mem_d[idx_q] = '0;
    end else if (wr_take) begin
      mem_d[wr_idx] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Every stage only loads on a valid, so the last stage holds rd_data between reads.
  always_comb begin
    vld_d[0] = rden;
    dat_d[0] = rden ? rd_val : dat_q[0];
    for (int k = 1; k < RD_LAT; k++) begin
      vld_d[k] = vld_q[k-1];
      dat_d[k] = vld_q[k-1] ? dat_q[k-1] : dat_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q      <= '0;
      addr_err_q <= 1'b0;
      for (int k = 0; k < RD_LAT; k++) dat_q[k] <= '0;
    end else begin
      vld_q      <= vld_d;
      addr_err_q <= addr_err_d;
      for (int k = 0; k < RD_LAT; k++) dat_q[k] <= dat_d[k];
    end
  end

  always_comb begin
    rd_valid = vld_q[RD_LAT-1];
    rd_data  = dat_q[RD_LAT-1];
    addr_err = addr_err_q;
  end

endmodule

// File: rtl/matrix_bank_regfile.sv
// NUMBANKS independent matrix banks, each with its own write, read and clear ports.
// Read data RD_LAT edges after rden at 1/cycle per bank; no backpressure.
module matrix_bank_regfile
  import matrix_regfile_pkg::*;
#(
  parameter int DW       = 16,
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int NUMBANKS = 4,
  parameter int RD_LAT   = 1,
  parameter int WR_FWD   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wren        [0:NUMBANKS-1],
  input  logic [$clog2(ROWS):0] row_wr_addr [0:NUMBANKS-1],
  input  logic [$clog2(COLS):0] col_wr_addr [0:NUMBANKS-1],
  input  logic [DW-1:0]         wr_data     [0:NUMBANKS-1],
  input  logic                  rden        [0:NUMBANKS-1],
  input  logic [$clog2(ROWS):0] row_rd_addr [0:NUMBANKS-1],
  input  logic [$clog2(COLS):0] col_rd_addr [0:NUMBANKS-1],
  output logic [DW-1:0]         rd_data     [0:NUMBANKS-1],
  output logic                  rd_valid    [0:NUMBANKS-1],
  input  logic                  clr_req     [0:NUMBANKS-1],
  output logic                  clr_busy    [0:NUMBANKS-1],
  output logic                  addr_err    [0:NUMBANKS-1]
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("matrix_bank_regfile: RD_LAT must be 1 or 2");
  end

  for (genvar b = 0; b < NUMBANKS; b++) begin : g_bank
    regfile_bank #(
      .DW     (DW),
      .ROWS   (ROWS),
      .COLS   (COLS),
      .RD_LAT (RD_LAT),
      .WR_FWD (WR_FWD)
    ) u_bank (
      .clk         (clk),
      .rst_n       (rst_n),
      .wren        (wren[b]),
      .row_wr_addr (row_wr_addr[b]),
      .col_wr_addr (col_wr_addr[b]),
      .wr_data     (wr_data[b]),
      .rden        (rden[b]),
      .row_rd_addr (row_rd_addr[b]),
      .col_rd_addr (col_rd_addr[b]),
      .rd_data     (rd_data[b]),
      .rd_valid    (rd_valid[b]),
      .clr_req     (clr_req[b]),
      .clr_busy    (clr_busy[b]),
      .addr_err    (addr_err[b])
    );
  end

endmodule
